// File: rtl/bus_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_map_pkg
//  Description : Shared types and memory-map constants for the 68000 bus
//                cycle glue (region codes, controller states, region
//                base/mask pairs, CPU-space function code).
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package bus_map_pkg;

   typedef enum logic [2:0] {
      REG_NONE = 3'd0,
      REG_ROM  = 3'd1,
      REG_RAM  = 3'd2,
      REG_IO   = 3'd3,
      REG_AVEC = 3'd4
   } region_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_ACK     = 3'd2,
      ST_FAULT   = 3'd3,
      ST_AVEC    = 3'd4,
      ST_RELEASE = 3'd5
   } state_t;

   // Each region is a 1 MiB window selected by the top address nibble.
   localparam logic [23:0] ROM_BASE = 24'h000000;
   localparam logic [23:0] ROM_MASK = 24'hF00000;
   localparam logic [23:0] RAM_BASE = 24'h100000;
   localparam logic [23:0] RAM_MASK = 24'hF00000;
   localparam logic [23:0] IO_BASE  = 24'hF00000;
   localparam logic [23:0] IO_MASK  = 24'hF00000;

   localparam logic [2:0]  FC_CPU_SPACE = 3'b111;

   function automatic logic in_region(input logic [23:0] a,
                                      input logic [23:0] base,
                                      input logic [23:0] mask);
      return (a & mask) == base;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bus_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : bus_addr_decode
//  Description : Purely combinational region decoder. CPU space (fc=7)
//                overrides the address map and selects autovector. A write
//                to ROM is flagged illegal.
//  Ports       : fc      in  3   function code
//                addr    in  24  byte address
//                read    in  1   1 = read, 0 = write
//                region  out 3   decoded region (region_t)
//                illegal out 1   access not permitted in the decoded region
//  Revision    : 1.0  initial release
// ============================================================================
module bus_addr_decode
   import bus_map_pkg::*;
(
   input  logic [2:0]  fc,
   input  logic [23:0] addr,
   input  logic        read,
   output region_t     region,
   output logic        illegal
);

   always_comb begin
      region  = REG_NONE;
      illegal = 1'b0;
      if (fc == FC_CPU_SPACE) begin
         region = REG_AVEC;
      end else if (in_region(addr, ROM_BASE, ROM_MASK)) begin
         region  = REG_ROM;
         illegal = ~read;
      end else if (in_region(addr, RAM_BASE, RAM_MASK)) begin
         region = REG_RAM;
      end else if (in_region(addr, IO_BASE, IO_MASK)) begin
         region = REG_IO;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_cycle_ctrl
//  Description : 68000 bus cycle sequencer. Decodes each cycle, drives chip
//                selects and strobes, inserts per-region wait states and
//                terminates with DTACK, VPA (autovector) or BERR.
//  Ports       : clk        in  1   CPU clock
//                reset      in  1   synchronous, active-high
//                as_n       in  1   address strobe
//                uds_n      in  1   upper data strobe
//                lds_n      in  1   lower data strobe
//                read       in  1   1 = read, 0 = write
//                fc         in  3   function code
//                addr       in  24  byte address
//                io_ready_n in  1   slow I/O ready
//                dtack_n, berr_n, vpa_n                 out  cycle termination
//                rom_cs_n, ram_cs_n, io_cs_n            out  chip selects
//                oe_n, we_hi_n, we_lo_n                 out  strobes
//  Revision    : 1.0  initial release
// ============================================================================
module bus_cycle_ctrl
   import bus_map_pkg::*;
#(
   parameter int ROM_WAIT = 2,
   parameter int RAM_WAIT = 0,
   parameter int IO_WAIT  = 1,
   parameter int TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        as_n,
   input  logic        uds_n,
   input  logic        lds_n,
   input  logic        read,
   input  logic [2:0]  fc,
   input  logic [23:0] addr,
   input  logic        io_ready_n,
   output logic        dtack_n,
   output logic        berr_n,
   output logic        vpa_n,
   output logic        rom_cs_n,
   output logic        ram_cs_n,
   output logic        io_cs_n,
   output logic        oe_n,
   output logic        we_hi_n,
   output logic        we_lo_n
);

   localparam logic [3:0] ROM_W = 4'(ROM_WAIT);
   localparam logic [3:0] RAM_W = 4'(RAM_WAIT);
   localparam logic [3:0] IO_W  = 4'(IO_WAIT);
   localparam logic [7:0] TMO   = 8'(TIMEOUT);

   state_t      state, state_nxt;
   region_t     region_q, region_nxt;
   logic        read_q, read_nxt;
   logic [3:0]  wait_cnt, wait_nxt;
   logic [7:0]  tmo_cnt, tmo_nxt, tmo_inc;
   logic        tmo_hit;

   region_t     dec_region;
   logic        dec_illegal;

   logic        cs_active;

   bus_addr_decode u_decode (
      .fc      (fc),
      .addr    (addr),
      .read    (read),
      .region  (dec_region),
      .illegal (dec_illegal)
   );

   function automatic logic [3:0] region_wait(input region_t r);
      case (r)
         REG_ROM: return ROM_W;
         REG_RAM: return RAM_W;
         REG_IO:  return IO_W;
         default: return 4'd0;
      endcase
   endfunction

   // Saturating increment; the value the counter would take on this edge.
   assign tmo_inc = (tmo_cnt == TMO) ? tmo_cnt : tmo_cnt + 8'd1;
   assign tmo_hit = (tmo_inc == TMO);

   always_comb begin
      state_nxt  = state;
      region_nxt = region_q;
      read_nxt   = read_q;
      wait_nxt   = wait_cnt;
      tmo_nxt    = tmo_cnt;
      case (state)
         ST_IDLE: begin
            if (!as_n) begin
               region_nxt = dec_region;
               read_nxt   = read;
               wait_nxt   = region_wait(dec_region);
               tmo_nxt    = 8'd0;
               if (dec_region == REG_AVEC)
                  state_nxt = ST_AVEC;
               else if (dec_region == REG_NONE || dec_illegal)
                  state_nxt = ST_FAULT;
               else
                  state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            tmo_nxt = tmo_inc;
            if (as_n) begin
               // CPU abandoned the cycle: no DTACK is ever issued.
               state_nxt = ST_RELEASE;
            end else if (tmo_hit) begin
               state_nxt = ST_FAULT;
            end else if (wait_cnt == 4'd0) begin
               if (region_q != REG_IO || !io_ready_n)
                  state_nxt = ST_ACK;
            end else begin
               wait_nxt = wait_cnt - 4'd1;
            end
         end
         ST_ACK, ST_FAULT, ST_AVEC: begin
            tmo_nxt = tmo_inc;
            if (as_n)
               state_nxt = ST_RELEASE;
         end
         ST_RELEASE: begin
            state_nxt = ST_IDLE;
            wait_nxt  = 4'd0;
            tmo_nxt   = 8'd0;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so each strobe changes on
   // the same edge as the transition that calls for it.
   assign cs_active = (state_nxt == ST_WAIT) || (state_nxt == ST_ACK);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         region_q <= REG_NONE;
         read_q   <= 1'b1;
         wait_cnt <= 4'd0;
         tmo_cnt  <= 8'd0;
         dtack_n  <= 1'b1;
         berr_n   <= 1'b1;
         vpa_n    <= 1'b1;
         rom_cs_n <= 1'b1;
         ram_cs_n <= 1'b1;
         io_cs_n  <= 1'b1;
         oe_n     <= 1'b1;
         we_hi_n  <= 1'b1;
         we_lo_n  <= 1'b1;
      end else begin
         state    <= state_nxt;
         region_q <= region_nxt;
         read_q   <= read_nxt;
         wait_cnt <= wait_nxt;
         tmo_cnt  <= tmo_nxt;
         dtack_n  <= ~(state_nxt == ST_ACK);
         berr_n   <= ~(state_nxt == ST_FAULT);
         vpa_n    <= ~(state_nxt == ST_AVEC);
         rom_cs_n <= ~(cs_active && region_nxt == REG_ROM);
         ram_cs_n <= ~(cs_active && region_nxt == REG_RAM);
         io_cs_n  <= ~(cs_active && region_nxt == REG_IO);
         oe_n     <= ~(cs_active && read_nxt);
         // Data strobes are taken live: on writes they assert a state after AS.
         we_hi_n  <= ~(cs_active && !read_nxt && !uds_n);
         we_lo_n  <= ~(cs_active && !read_nxt && !lds_n);
      end
   end

endmodule
`default_nettype wire

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
- Glue controller that sequences every 68000 bus cycle on the board.
- Samples AS/UDS/LDS/R/W/FC/address, decodes the region and drives chip selects and read/write strobes.
- Inserts per-region wait states, then terminates the cycle with DTACK, VPA (autovector) or BERR (unmapped, illegal, timeout).
- Sits between the CPU pins and the ROM, RAM and I/O devices; verified against the fake68k bench model.

Parameters:
- ROM_WAIT, 2, wait cycles before DTACK for ROM (0..15)
- RAM_WAIT, 0, wait cycles before DTACK for RAM (0..15)
- IO_WAIT, 1, minimum wait cycles for I/O before io_ready_n is honoured (0..15)
- TIMEOUT, 64, cycles from AS sample to forced BERR (IO_WAIT+2..255)

Ports:
- clk  in  1  CPU clock; all inputs are synchronous to it
- reset  in  1  synchronous, active-high
- as_n  in  1  address strobe
- uds_n  in  1  upper data strobe
- lds_n  in  1  lower data strobe
- read  in  1  1 = read, 0 = write
- fc  in  3  function code
- addr  in  24  byte address (bit 0 ignored)
- io_ready_n  in  1  slow I/O device ready
- dtack_n  out  1  data acknowledge
- berr_n  out  1  bus error
- vpa_n  out  1  valid peripheral address (autovector)
- rom_cs_n, ram_cs_n, io_cs_n  out  1 each  chip selects
- oe_n  out  1  read output enable
- we_hi_n, we_lo_n  out  1 each  byte write enables

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. While reset is sampled high, all outputs are 1 (deasserted) after the edge, state = IDLE, counters = 0. Reset mid-cycle has the same effect; no partial DTACK is emitted.
- Memory map:
  - ROM 0x000000-0x0FFFFF
  - RAM 0x100000-0x1FFFFF
  - IO 0xF00000-0xFFFFFF
  - anything else is unmapped
  - fc=3'b111 (CPU space) overrides the map and selects autovector
- States: IDLE, WAIT, ACK, FAULT, AVEC, RELEASE.
- IDLE:
  - At edge N with as_n=0: latch region, read and wait count; start the timeout counter at 0.
  - Mapped and legal: go to WAIT; the matching cs_n goes low after edge N.
  - ROM write, or unmapped: go to FAULT; berr_n goes low after edge N; no cs asserted.
  - fc=7: go to AVEC; vpa_n goes low after edge N.
- WAIT:
  - Each edge decrements the wait count.
  - When the count is 0 (and io_ready_n=0 for IO), go to ACK; dtack_n goes low after edge N+1+W, where W is the region wait.
  - IO with io_ready_n=1 holds in WAIT.
- Timeout:
  - The counter increments every edge outside IDLE and RELEASE.
  - If it reaches TIMEOUT while in WAIT: go to FAULT. All cs are released and berr_n goes low on the same edge.
  - DTACK and BERR are never low together.
- ACK, FAULT, AVEC: hold cs/dtack, berr or vpa until as_n=1 is sampled, then go to RELEASE. All outputs return high after that edge.
- RELEASE: one cycle with everything deasserted, then IDLE. A new as_n=0 seen in RELEASE is ignored until IDLE, which guarantees one idle cycle between cycles.
- Abort: as_n=1 sampled in WAIT goes directly to RELEASE, with no DTACK.
- Strobes (registered, re-evaluated every edge):
  - oe_n = ~(state in WAIT/ACK & read & cs active)
  - we_hi_n = ~(cs active & ~read & ~uds_n)
  - we_lo_n likewise with lds_n
  - UDS/LDS are sampled live, because they assert one state after AS on writes.
- Wait counter is 4 bits and timeout counter is 8 bits; neither wraps (the timeout counter saturates at TIMEOUT).

Decomposition:
- Package bus_map_pkg:
  - region enum (REG_NONE, REG_ROM, REG_RAM, REG_IO, REG_AVEC)
  - state enum
  - region base/mask constants
  - FC_CPU_SPACE=3'b111
- Sub-module bus_addr_decode: purely combinational addr/fc/read -> region plus illegal flag. It is reused later by the DMA arbiter.

Test Plan:
- ROM read at 0x000400, RAM_WAIT=0, ROM_WAIT=2 -> rom_cs_n and oe_n low from edge N+1, dtack_n low after edge N+3; data latched by fake68k; all high one edge after as_n rises.
- RAM word write at 0x100010 -> ram_cs_n low at N+1; we_hi_n and we_lo_n low once UDS/LDS assert; dtack_n low at N+1; RELEASE cycle observed.
- IO read at 0xF00002 with io_ready_n held high 10 cycles -> dtack_n low exactly 1 edge after io_ready_n falls. Held high for 64 cycles -> berr_n low at TIMEOUT, io_cs_n high, dtack_n never low.
- Read at 0x400000 (unmapped) and write to 0x000000 (ROM) -> berr_n low after edge N, no cs asserted; fake68k reaches its bus-error states and completes.
- fc=7 interrupt acknowledge at 0xFFFFFF -> vpa_n low, io_cs_n stays high, dtack_n stays high.
- reset asserted during WAIT of a ROM read -> all outputs high after that edge; next cycle at 0x100000 completes normally.
